cordic_vec: RTL
===============

Name: cordic_vec

Overview:
- Vectoring-mode CORDIC that converts one lane of 16-bit sin/cos (I/Q) samples back into a 32-bit phase word and a magnitude.
- It is the inverse of the oscillator's rotation-mode CORDIC. It sits on the receive side after mixing, or in loopback behind the oscillator.
- Phase uses the same scaling as the phase accumulator: 2^32 LSB per turn.
- One instance per lane; 4 instances cover a 64-bit sample bus.

Parameters:
- ITER, 16, number of micro-rotation stages (legal 8..24).
- GUARD, 2, extra LSBs on the internal X/Y datapath.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- valid_i  in  1  input sample strobe
- sin_i  in  16  signed Q1.15 Y component
- cos_i  in  16  signed Q1.15 X component
- phase_o  out  32  unsigned phase, 0x0000_0000 = 0 rad, wraps mod 2^32
- mag_o  out  17  unsigned magnitude, including CORDIC gain (about 1.64676)
- valid_o  out  1  output strobe

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: phase_o=0, mag_o=0, valid_o=0, whole valid pipeline cleared.
- No backpressure: a sample is accepted on every cycle with valid_i=1. Bubbles propagate unchanged.
- Latency is exactly ITER+2 cycles from valid_i to valid_o: 1 pre-rotation stage, ITER iteration stages, 1 output register.
- Stage P (pre-rotation):
  - Sign-extend X and Y to 18+GUARD bits.
  - If cos_i<0: negate X and Y, set z=0x8000_0000.
  - Otherwise set z=0.
  - Result: X is non-negative, residual angle lies in (-90°, +90°].
- Stage i (0..ITER-1):
  - d = sign(Y): Y>=0 gives d=+1.
  - X' = X + d·(Y>>>i); Y' = Y − d·(X>>>i); z' = z + d·ATAN[i].
  - z arithmetic is 32-bit modulo 2^32.
- Output stage:
  - phase_o = z.
  - mag_o = X rounded half-up, dropping the GUARD bits, saturated to 17 bits.
- phase_o and mag_o load only when the final-stage valid is 1. They hold otherwise.
- Data registers advance every cycle; only the valid bits gate the outputs.
- Boundary cases:
  - (cos,sin)=(0,0) gives phase_o=0, mag_o=0.
  - (−32768,0) gives phase 0x8000_0000.
  - (0,−32768) gives 0xC000_0000.
  - Full-scale −32768 on both axes must not overflow: 2 integer headroom bits.
- Reset mid-operation: in-flight samples are discarded, no valid_o after reset deasserts until a new valid_i has travelled ITER+2 cycles.
- Accuracy: |phase error| ≤ 2^17 LSB for |input| ≥ 1024 with ITER=16.

Optional Feature:
- Macro: CORDIC_VEC_FREQ_EN.
- Defined:
  - Adds port freq_o (out, 32): the phase difference between consecutive valid outputs, phase_o(n) − phase_o(n−1) mod 2^32.
  - freq_o updates with valid_o; reset value 0.
  - The first valid output after reset gives freq_o=0.
  - Adds one 32-bit register plus a first-sample flag; latency unchanged.
- Undefined: port and logic absent.

Decomposition:
- Package cordic_pkg holds:
  - ATAN table: 24 entries of 32-bit round(atan(2^-i)·2^32/2π); entry 0 = 0x2000_0000.
  - Widths PHASE_W=32, SAMPLE_W=16.
  - Constants HALF_TURN=0x8000_0000 and QUARTER_TURN=0x4000_0000.
- The rotation-mode CORDIC also imports this package.
- One natural sub-module: cordic_vec_stage, parameterised by stage index, holding registered X/Y/z/valid. Instantiate it ITER times with generate.

Test Plan:
- Axis points, one per cycle: (32767,0), (0,32767), (−32768,0), (0,−32768) → after ITER+2 cycles:
  - phase_o 0x0000_0000, 0x4000_0000, 0x8000_0000, 0xC000_0000, each ±2^17.
  - mag_o about 53960 ±4 for the first two.
- Zero vector (0,0) → phase_o=0, mag_o=0.
- Loopback: oscillator with INC=0x3333_3333 drives lane 0 continuously →
  - phase_o steps 0x3333_3333 per sample ±2^17.
  - With CORDIC_VEC_FREQ_EN, freq_o = 0x3333_3333 ±2^18 from the second output on.
- Bubbles: valid_i pattern 1,0,0,1,1 → identical valid_o pattern delayed by exactly 18 cycles. Outputs hold during the gaps.
- Reset mid-stream: assert rst_i for 1 cycle 5 cycles after a burst of 10 valids →
  - All outputs 0 the next cycle.
  - No valid_o for the rest of the burst.
  - freq_o restarts at 0 on the first new sample.
- Random sweep: 10^4 random (cos,sin) with magnitude ≥ 1024 → phase error ≤ 2^17 LSB, mag error ≤ 0.1% against a reference model.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: phase scaling (2^32 LSB per turn), sample widths and
// the arctangent table used by both the rotation- and vectoring-mode CORDICs.
package cordic_pkg;

    localparam int unsigned PHASE_W  = 32;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned MAG_W    = SAMPLE_W + 1;

    typedef logic [PHASE_W-1:0] phase_t;

    localparam phase_t HALF_TURN    = 32'h8000_0000;
    localparam phase_t QUARTER_TURN = 32'h4000_0000;

    // round(atan(2^-idx) * 2^32 / (2*pi)) for idx = 0..23
    function automatic phase_t atan_entry(input int unsigned idx);
        phase_t a;
        case (idx)
            0:       a = 32'h2000_0000;
            1:       a = 32'h12E4_051E;
            2:       a = 32'h09FB_385B;
            3:       a = 32'h0511_11D4;
            4:       a = 32'h028B_0D43;
            5:       a = 32'h0145_D7E1;
            6:       a = 32'h00A2_F61E;
            7:       a = 32'h0051_7C55;
            8:       a = 32'h0028_BE53;
            9:       a = 32'h0014_5F2F;
            10:      a = 32'h000A_2F98;
            11:      a = 32'h0005_17CC;
            12:      a = 32'h0002_8BE6;
            13:      a = 32'h0001_45F3;
            14:      a = 32'h0000_A2FA;
            15:      a = 32'h0000_517D;
            16:      a = 32'h0000_28BE;
            17:      a = 32'h0000_145F;
            18:      a = 32'h0000_0A30;
            19:      a = 32'h0000_0518;
            20:      a = 32'h0000_028C;
            21:      a = 32'h0000_0146;
            22:      a = 32'h0000_00A3;
            23:      a = 32'h0000_0051;
            default: a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered vectoring micro-rotation: steers Y toward zero and accumulates
// the applied angle into z. Only the valid bit is reset.
module cordic_vec_stage
    import cordic_pkg::*;
#(
    parameter int unsigned STAGE = 0,
    parameter int unsigned W     = 20
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic               zero_i,
    input  logic [W-1:0]       x_i,
    input  logic [W-1:0]       y_i,
    input  logic [PHASE_W-1:0] z_i,
    output logic               valid_o,
    output logic               zero_o,
    output logic [W-1:0]       x_o,
    output logic [W-1:0]       y_o,
    output logic [PHASE_W-1:0] z_o
);

    localparam phase_t ATAN = atan_entry(STAGE);

    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;

    always_comb begin
        x_sh = $signed(x_i) >>> STAGE;
        y_sh = $signed(y_i) >>> STAGE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        zero_o <= zero_i;
        if (!y_i[W-1]) begin
            x_o <= x_i + y_sh;
            y_o <= y_i - x_sh;
            z_o <= z_i + ATAN;
        end else begin
            x_o <= x_i - y_sh;
            y_o <= y_i + x_sh;
            z_o <= z_i - ATAN;
        end
    end

endmodule

// File: rtl/cordic_vec.sv
// Vectoring-mode CORDIC: one lane of Q1.15 (cos, sin) to 32-bit phase and magnitude.
// Optional CORDIC_VEC_FREQ_EN adds freq_o, the phase step between valid outputs.
module cordic_vec
    import cordic_pkg::*;
#(
    parameter int unsigned ITER  = 16,
    parameter int unsigned GUARD = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    input  logic [SAMPLE_W-1:0] sin_i,
    input  logic [SAMPLE_W-1:0] cos_i,
    output logic [PHASE_W-1:0]  phase_o,
    output logic [MAG_W-1:0]    mag_o,
`ifdef CORDIC_VEC_FREQ_EN
    output logic [PHASE_W-1:0]  freq_o,
`endif
    output logic                valid_o
);

    localparam int unsigned W  = 18 + GUARD;
    localparam int unsigned RW = W + 1;
    localparam logic signed [RW-1:0] RND     = RW'((1 << GUARD) >> 1);
    localparam logic signed [RW-1:0] MAG_MAX = RW'((1 << MAG_W) - 1);

    logic signed [W-1:0] cos_ext;
    logic signed [W-1:0] sin_ext;
    logic                v_p;
    logic                zero_p;
    logic [W-1:0]        x_p;
    logic [W-1:0]        y_p;
    phase_t              z_p;

    logic                v_s    [ITER+1];
    logic                zero_s [ITER+1];
    logic [W-1:0]        x_s    [ITER+1];
    logic [W-1:0]        y_s    [ITER+1];
    phase_t              z_s    [ITER+1];

    logic signed [RW-1:0] x_round;
    logic signed [RW-1:0] x_shift;
    logic [MAG_W-1:0]     mag_sat;
    phase_t               phase_next;

    always_comb begin
        cos_ext = W'($signed(cos_i)) <<< GUARD;
        sin_ext = W'($signed(sin_i)) <<< GUARD;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_p <= 1'b0;
        end else begin
            v_p <= valid_i;
        end
    end

    // Left half-plane inputs are rotated by 180 deg so X starts non-negative.
    always_ff @(posedge clk_i) begin
        zero_p <= (cos_i == '0) && (sin_i == '0);
        if (cos_i[SAMPLE_W-1]) begin
            x_p <= -cos_ext;
            y_p <= -sin_ext;
            z_p <= HALF_TURN;
        end else begin
            x_p <= cos_ext;
            y_p <= sin_ext;
            z_p <= '0;
        end
    end

    assign v_s[0]    = v_p;
    assign zero_s[0] = zero_p;
    assign x_s[0]    = x_p;
    assign y_s[0]    = y_p;
    assign z_s[0]    = z_p;

    for (genvar g = 0; g < ITER; g++) begin : g_stage
        cordic_vec_stage #(
            .STAGE (g),
            .W     (W)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .valid_i (v_s[g]),
            .zero_i  (zero_s[g]),
            .x_i     (x_s[g]),
            .y_i     (y_s[g]),
            .z_i     (z_s[g]),
            .valid_o (v_s[g+1]),
            .zero_o  (zero_s[g+1]),
            .x_o     (x_s[g+1]),
            .y_o     (y_s[g+1]),
            .z_o     (z_s[g+1])
        );
    end

    // A zero vector keeps Y=0 so every stage would add +atan; force its phase to 0.
    always_comb begin
        x_round    = RW'($signed(x_s[ITER])) + RND;
        x_shift    = x_round >>> GUARD;
        phase_next = zero_s[ITER] ? '0 : z_s[ITER];
        if (x_shift[RW-1]) begin
            mag_sat = '0;
        end else if (x_shift > MAG_MAX) begin
            mag_sat = '1;
        end else begin
            mag_sat = x_shift[MAG_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            phase_o <= '0;
            mag_o   <= '0;
        end else begin
            valid_o <= v_s[ITER];
            if (v_s[ITER]) begin
                phase_o <= phase_next;
                mag_o   <= mag_sat;
            end
        end
    end

`ifdef CORDIC_VEC_FREQ_EN
    logic seen_q;

    // phase_o still holds the previous valid output when the next one arrives.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            freq_o <= '0;
            seen_q <= 1'b0;
        end else if (v_s[ITER]) begin
            freq_o <= seen_q ? (phase_next - phase_o) : '0;
            seen_q <= 1'b1;
        end
    end
`endif

endmodule
